// File: rtl/aes_pkg.sv
// aes_pkg: keylen codes, round counts, FSM/update encodings and GF(2^8) helpers for the AES encipher engine
package aes_pkg;
  typedef enum logic [1:0] {KEY_128 = 2'd0, KEY_192 = 2'd1, KEY_256 = 2'd2, KEY_RSV = 2'd3} keylen_e;
  localparam int NR_128 = 10;
  localparam int NR_192 = 12;
  localparam int NR_256 = 14;
  typedef enum logic [2:0] {IDLE, INIT, SBOX, MAIN, FINAL} state_e;
  typedef enum logic [2:0] {UPD_NONE, UPD_INIT, UPD_SBOX, UPD_MAIN, UPD_FINAL} upd_e;
  function automatic int nr_of(input logic [1:0] keylen);
    return keylen == KEY_192 ? NR_192 : keylen == KEY_256 ? NR_256 : NR_128;
  endfunction
  function automatic logic [7:0] gm2(input logic [7:0] x);
    return {x[6:0], 1'b0} ^ (8'h1b & {8{x[7]}});
  endfunction
  function automatic logic [7:0] gm3(input logic [7:0] x);
    return gm2(x) ^ x;
  endfunction
  function automatic logic [31:0] mixw(input logic [31:0] w);
    return {gm2(w[31:24]) ^ gm3(w[23:16]) ^ w[15:8] ^ w[7:0],
            w[31:24] ^ gm2(w[23:16]) ^ gm3(w[15:8]) ^ w[7:0],
            w[31:24] ^ w[23:16] ^ gm2(w[15:8]) ^ gm3(w[7:0]),
            gm3(w[31:24]) ^ w[23:16] ^ w[15:8] ^ gm2(w[7:0])};
  endfunction
endpackage

// File: rtl/aes_round_datapath.sv
// aes_round_datapath: combinational round tail; state/round_key in, main_block (ShiftRows+MixColumns+AddRoundKey) and final_block (ShiftRows+AddRoundKey) out
module aes_round_datapath
  import aes_pkg::*;
(
  input  logic [127:0] state,
  input  logic [127:0] round_key,
  output logic [127:0] main_block,
  output logic [127:0] final_block
);
  logic [31:0] w0, w1, w2, w3;
  logic [127:0] sr;
  assign {w0, w1, w2, w3} = state;
  assign sr = {w0[31:24], w1[23:16], w2[15:8], w3[7:0],
               w1[31:24], w2[23:16], w3[15:8], w0[7:0],
               w2[31:24], w3[23:16], w0[15:8], w1[7:0],
               w3[31:24], w0[23:16], w1[15:8], w2[7:0]};
  assign main_block = {mixw(sr[127:96]), mixw(sr[95:64]), mixw(sr[63:32]), mixw(sr[31:0])} ^ round_key;
  assign final_block = sr ^ round_key;
endmodule

// File: rtl/aes_encipher_block_mp.sv
// aes_encipher_block_mp: multi-lane AES-128/192/256 encipher engine; clk/reset, next/keylen start, round/round_key to key memory, sboxw/new_sboxw to S-boxes, block in, new_block/ready out
module aes_encipher_block_mp
  import aes_pkg::*;
#(
  parameter int SBOX_LANES = 1,
  parameter int ROUND_W = 4
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      next,
  input  logic [1:0]                keylen,
  output logic [ROUND_W-1:0]        round,
  input  logic [127:0]              round_key,
  output logic [32*SBOX_LANES-1:0]  sboxw,
  input  logic [32*SBOX_LANES-1:0]  new_sboxw,
  input  logic [127:0]              block,
  output logic [127:0]              new_block,
  output logic                      ready
);
  localparam int S = 4 / SBOX_LANES;
  localparam int SW = S > 1 ? $clog2(S) : 1;
  if (SBOX_LANES != 1 && SBOX_LANES != 2 && SBOX_LANES != 4) begin : g_bad_lanes
    $error("SBOX_LANES must be 1, 2 or 4");
  end
  state_e state;
  upd_e upd;
  logic [ROUND_W-1:0] round_ctr, nr;
  logic [SW-1:0] sword_ctr;
  logic [127:0] sub_block, main_block, final_block, blk_nxt;
  logic last;
  aes_round_datapath u_dp (
    .state(new_block),
    .round_key(round_key),
    .main_block(main_block),
    .final_block(final_block)
  );
  always_comb begin
    sboxw = '0;
    sub_block = new_block;
    if (state == SBOX)
      for (int i = 0; i < SBOX_LANES; i++) begin
        sboxw[32*i +: 32] = new_block[127-32*(int'(sword_ctr)*SBOX_LANES+i) -: 32];
        sub_block[127-32*(int'(sword_ctr)*SBOX_LANES+i) -: 32] = new_sboxw[32*i +: 32];
      end
  end
  assign last = sword_ctr == SW'(S - 1);
  assign upd = state == INIT ? UPD_INIT : state == SBOX ? UPD_SBOX : state == MAIN ? UPD_MAIN :
               state == FINAL ? UPD_FINAL : UPD_NONE;
  assign blk_nxt = upd == UPD_INIT ? block ^ round_key : upd == UPD_SBOX ? sub_block :
                   upd == UPD_MAIN ? main_block : upd == UPD_FINAL ? final_block : new_block;
  assign round = round_ctr;
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      round_ctr <= '0;
      sword_ctr <= '0;
      nr <= '0;
      new_block <= '0;
      ready <= 1'b1;
    end else begin
      new_block <= blk_nxt;
      case (state)
        IDLE: if (next) begin
          ready <= 1'b0;
          round_ctr <= '0;
          nr <= ROUND_W'(nr_of(keylen));
          state <= INIT;
        end
        INIT: begin
          round_ctr <= ROUND_W'(1);
          sword_ctr <= '0;
          state <= SBOX;
        end
        SBOX: begin
          sword_ctr <= last ? '0 : sword_ctr + 1'b1;
          if (last) state <= round_ctr < nr ? MAIN : FINAL;
        end
        MAIN: begin
          round_ctr <= round_ctr + 1'b1;
          sword_ctr <= '0;
          state <= SBOX;
        end
        FINAL: begin
          ready <= 1'b1;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: doc/aes_encipher_block_mp.md
Name: aes_encipher_block_mp

Overview:
Parametrised multi-lane AES encipher round engine, successor to the single-lane encipher block. It supports AES-128, AES-192 and AES-256 through a 2-bit key-length mode. SubBytes throughput is selectable: 1, 2 or 4 words per cycle. Round keys come from the external key-memory block, indexed by the `round` output; S-boxes are external, shared and combinational. It sits between the AES core control/register logic and the key memory plus S-box array.

Parameters:
SBOX_LANES, 1, number of 32-bit words substituted per cycle; legal values 1, 2, 4 (others: elaboration error).
ROUND_W, 4, width of the round index.

Ports:
clk  in  1  clock, rising-edge.
reset  in  1  synchronous, active-high reset.
next  in  1  start pulse; sampled only in IDLE.
keylen  in  2  0=AES-128 (10 rounds), 1=AES-192 (12), 2=AES-256 (14), 3=reserved, treated as AES-128.
round  out  ROUND_W  current round index presented to key memory.
round_key  in  128  key for `round`, valid combinationally in the same cycle.
sboxw  out  32*SBOX_LANES  words to substitute; lane i at bits [32*i+31:32*i].
new_sboxw  in  32*SBOX_LANES  substituted words, same cycle, same lane mapping.
block  in  128  plaintext; word 0 = [127:96]; sampled in INIT.
new_block  out  128  state/ciphertext register.
ready  out  1  high when idle and the result is valid.

Behaviour:
- Reset values: all outputs 0 except ready=1. State IDLE, round_ctr=0, sword_ctr=0, block registers 0.
- Constants:
  - S = 4/SBOX_LANES (SBOX cycles per round).
  - Nr latched from keylen when next is accepted.
  - A keylen change mid-operation is ignored.
- IDLE:
  - next=1: ready<=0, round_ctr<=0, latch Nr, go to INIT.
  - next=0: hold; new_block retains the last result.
- INIT (1 cycle): new_block <= block ^ round_key (round=0); round_ctr<=1; sword_ctr<=0; go to SBOX.
- SBOX (S cycles):
  - Cycle j, lane i: sboxw lane i = state word j*SBOX_LANES+i; that word <= new_sboxw lane i.
  - sword_ctr increments each cycle, wrapping at S-1.
  - On the last group: go to MAIN if round_ctr<Nr, else go to FINAL.
- MAIN (1 cycle): new_block <= MixColumns(ShiftRows(state)) ^ round_key; round_ctr++; sword_ctr<=0; go to SBOX.
- FINAL (1 cycle, round_ctr=Nr): new_block <= ShiftRows(state) ^ round_key; ready<=1; go to IDLE; round_ctr holds Nr.
- sboxw is 0 outside SBOX.
- Latency: ready returns high 1+Nr*(S+1) edges after the edge that accepted next.
  - AES-128: 51 cycles at S=4, 21 at S=1.
  - AES-256: 71 at S=4, 29 at S=1.
- next while busy: ignored, no restart, no queuing.
- next held high: a new operation starts in the first IDLE cycle after completion; ready is high for exactly 1 cycle.
- reset mid-operation: the next edge forces IDLE, ready=1, new_block=0, round=0.
- GF arithmetic: gm2(x) = {x[6:0],0} ^ (0x1b & {8{x[7]}}); gm3 = gm2 ^ x; standard column matrix [2 3 1 1].
- ShiftRows: out word c byte r = in word (c+r) mod 4 byte r, where byte 0 is the MSB of the word.

Decomposition:
- Package aes_pkg holds:
  - keylen codes and round counts (10/12/14).
  - FSM state encodings IDLE/INIT/SBOX/MAIN/FINAL.
  - update-type codes.
  - gm2/gm3/mixw functions.
- One sub-module: aes_round_datapath, combinational, 128-bit state + round key in.
  - Produces the main-round result (ShiftRows→MixColumns→AddRoundKey) and the final-round result (ShiftRows→AddRoundKey).
  - Unit-testable against FIPS-197 Appendix B intermediates.

Test Plan:
- FIPS-197 App. B, AES-128, SBOX_LANES=1: key 2b7e151628aed2a6abf7158809cf4f3c, pt 3243f6a8885a308d313198a2e0370734 -> new_block 3925841d02dc09fbdc118597196a0b32; ready low exactly 51 cycles.
- App. C.1/C.2/C.3, key 000102..1f truncated per mode, pt 00112233445566778899aabbccddeeff, keylen 0/1/2 -> 69c4e0d86a7b0430d8cdb78070b4c55a / dda97ca4864cdfe06eaf70a0ec0d7191 / 8ea2b7ca516745bfeafc49904b496089. Repeat for SBOX_LANES=1,2,4 with latencies 1+Nr*(S+1).
- Round sequencing: the bench key-model asserts round is 0 at INIT, increments once per MAIN, and equals Nr at FINAL. sboxw is nonzero only in SBOX.
- next pulsed at cycle 10 of an AES-128 run -> ignored; single result, correct ciphertext, ready rises at the normal cycle.
- reset asserted mid-SBOX of round 5 -> next cycle ready=1, new_block=0, round=0. A following run yields the correct App. B ciphertext.
- next held high with keylen=3 -> back-to-back AES-128 runs, ready high 1 cycle between runs, each result 3925841d02dc09fbdc118597196a0b32.
